// File: rtl/mux_sel_ctrl.sv
// Upstream controller for the 2:1 data mux: two one-entry holding registers feed
// mux i0/i1, and a round-robin (or fixed-priority) FSM drives the select and out_valid.
module mux_sel_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter bit          RR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic [WIDTH-1:0] mux_i0,
   output logic [WIDTH-1:0] mux_i1,
   output logic             mux_s,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2
   } state_e;

   state_e           state_q;
   state_e           grant_c;
   logic             last_q;
   logic             out_valid_q;
   logic             mux_s_q;
   logic [WIDTH-1:0] buf0_q, buf0_d;
   logic [WIDTH-1:0] buf1_q, buf1_d;
   logic             full0_q, full0_d;
   logic             full1_q, full1_d;
   logic             pop0, pop1;
   logic             push0, push1;

   assign out_valid = out_valid_q;
   assign mux_s     = mux_s_q;
   assign mux_i0    = buf0_q;
   assign mux_i1    = buf1_q;

   // A holding register may refill on the same cycle its word is consumed.
   assign pop0      = out_valid_q & out_ready & ~mux_s_q;
   assign pop1      = out_valid_q & out_ready &  mux_s_q;
   assign in0_ready = ~full0_q | pop0;
   assign in1_ready = ~full1_q | pop1;
   assign push0     = in0_valid & in0_ready;
   assign push1     = in1_valid & in1_ready;

   always_comb begin
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      full0_d = full0_q & ~pop0;
      full1_d = full1_q & ~pop1;
      if (push0) begin
         buf0_d  = in0_data;
         full0_d = 1'b1;
      end
      if (push1) begin
         buf1_d  = in1_data;
         full1_d = 1'b1;
      end
   end

   // Grant from next-cycle occupancy; on a tie, round-robin favours the source not served last.
   always_comb begin
      grant_c = IDLE;
      if (full0_d && full1_d) begin
         grant_c = (RR_EN && !last_q) ? SEND1 : SEND0;
      end else if (full0_d) begin
         grant_c = SEND0;
      end else if (full1_d) begin
         grant_c = SEND1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf0_q  <= '0;
         buf1_q  <= '0;
         full0_q <= 1'b0;
         full1_q <= 1'b0;
      end else begin
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
         full0_q <= full0_d;
         full1_q <= full1_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         out_valid_q <= 1'b0;
         mux_s_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE, SEND0, SEND1: begin
               // The selection is held until the consumer pops the granted word.
               if (state_q == IDLE || pop0 || pop1) begin
                  state_q     <= grant_c;
                  out_valid_q <= (grant_c != IDLE);
                  mux_s_q     <= (grant_c == SEND1);
                  if (grant_c != IDLE) begin
                     last_q <= (grant_c == SEND1);
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               mux_s_q     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl: one round-robin and one fixed-priority instance,
// steered by fp_mode, checked against hand-computed pop sequences.
module tb_mux_sel_ctrl;
   localparam int unsigned W = 16;

   logic         clk;
   logic         rst_n;
   logic         fp_mode;
   logic         in0_valid, in1_valid, out_ready;
   logic [W-1:0] in0_data, in1_data;

   logic         rr_r0, rr_r1, rr_s, rr_ov;
   logic [W-1:0] rr_i0, rr_i1;
   logic         fp_r0, fp_r1, fp_s, fp_ov;
   logic [W-1:0] fp_i0, fp_i1;
   logic         s_r0, s_r1, s_s, s_ov;
   logic [W-1:0] s_i0, s_i1;

   int           n_tests;
   int           n_fail;
   int           first_pop;
   int           last_pop;
   logic [16:0]  exp_q[$];

   mux_sel_ctrl #(.WIDTH(W), .RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_valid(in0_valid & ~fp_mode), .in0_data(in0_data), .in0_ready(rr_r0),
      .in1_valid(in1_valid & ~fp_mode), .in1_data(in1_data), .in1_ready(rr_r1),
      .mux_i0(rr_i0), .mux_i1(rr_i1), .mux_s(rr_s), .out_valid(rr_ov),
      .out_ready(out_ready & ~fp_mode)
   );

   mux_sel_ctrl #(.WIDTH(W), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .in0_valid(in0_valid & fp_mode), .in0_data(in0_data), .in0_ready(fp_r0),
      .in1_valid(in1_valid & fp_mode), .in1_data(in1_data), .in1_ready(fp_r1),
      .mux_i0(fp_i0), .mux_i1(fp_i1), .mux_s(fp_s), .out_valid(fp_ov),
      .out_ready(out_ready & fp_mode)
   );

   assign s_r0 = fp_mode ? fp_r0 : rr_r0;
   assign s_r1 = fp_mode ? fp_r1 : rr_r1;
   assign s_s  = fp_mode ? fp_s  : rr_s;
   assign s_ov = fp_mode ? fp_ov : rr_ov;
   assign s_i0 = fp_mode ? fp_i0 : rr_i0;
   assign s_i1 = fp_mode ? fp_i1 : rr_i1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b0;
      in0_data  = '0;
      in1_data  = '0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Source k offers n_k words bk, bk+1, ...; every pop is compared with the head of exp_q.
   task automatic stream(input int n0, input int n1, input logic [W-1:0] b0, input logic [W-1:0] b1);
      int          k0 = 0;
      int          k1 = 0;
      int          cyc = 0;
      logic        acc0, acc1;
      logic [16:0] got, exp;
      first_pop = -1;
      last_pop  = -1;
      out_ready = 1'b1;
      in0_valid = (n0 > 0);
      in0_data  = b0;
      in1_valid = (n1 > 0);
      in1_data  = b1;
      while (exp_q.size() > 0 && cyc < 200) begin
         @(negedge clk);
         acc0 = in0_valid & s_r0;
         acc1 = in1_valid & s_r1;
         if (s_ov) begin
            got = {s_s, s_s ? s_i1 : s_i0};
            exp = exp_q.pop_front();
            check("stream_word", 64'(got), 64'(exp));
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
         @(posedge clk);
         #1;
         if (acc0) begin
            k0++;
            in0_valid = (k0 < n0);
            in0_data  = b0 + W'(k0);
         end
         if (acc1) begin
            k1++;
            in1_valid = (k1 < n1);
            in1_data  = b1 + W'(k1);
         end
         cyc++;
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      check("stream_drained", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      fp_mode   = 1'b0;
      rst_n     = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b0;
      in0_data  = '0;
      in1_data  = '0;

      // Reset then idle
      #3;
      check("in_reset", 64'({s_ov, s_s, s_r0, s_r1, s_i0, s_i1}), 64'({4'b0011, 16'h0, 16'h0}));
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle", 64'({s_ov, s_s, s_r0, s_r1, s_i0, s_i1}), 64'({4'b0011, 16'h0, 16'h0}));
      end
      @(posedge clk);
      #1;

      // Single source 0 streaming
      do_reset();
      for (int i = 1; i <= 5; i++) exp_q.push_back({1'b0, W'(i)});
      stream(5, 0, 16'h0001, 16'h0000);
      check("single_first_cycle", 64'(first_pop), 64'(1));
      check("single_last_cycle", 64'(last_pop), 64'(5));

      // Simultaneous first request
      do_reset();
      exp_q.push_back({1'b0, 16'hAAAA});
      exp_q.push_back({1'b1, 16'h5555});
      stream(1, 1, 16'hAAAA, 16'h5555);
      check("simul_first_cycle", 64'(first_pop), 64'(1));
      check("simul_last_cycle", 64'(last_pop), 64'(2));

      // Round-robin fairness
      do_reset();
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({1'b0, 16'h0A00 + W'(i)});
         exp_q.push_back({1'b1, 16'h0B00 + W'(i)});
      end
      stream(8, 8, 16'h0A00, 16'h0B00);
      check("rr_span", 64'(last_pop - first_pop), 64'(15));

      // Fixed priority: all source-0 words first
      fp_mode = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 16'h0A00 + W'(i)});
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 16'h0B00 + W'(i)});
      stream(8, 8, 16'h0A00, 16'h0B00);
      fp_mode = 1'b0;

      // Backpressure hold in SEND1
      do_reset();
      in1_valid = 1'b1;
      in1_data  = 16'h1234;
      @(negedge clk);
      check("bp_accept_ready", 64'(s_r1), 64'(1));
      @(posedge clk);
      #1;
      in1_data = 16'h5678;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_hold", 64'({s_ov, s_s, s_r1, s_i1}), 64'({3'b110, 16'h1234}));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_pop", 64'({s_ov, s_s, s_r1, s_i1}), 64'({3'b111, 16'h1234}));
      @(posedge clk);
      #1;
      in1_valid = 1'b0;
      @(negedge clk);
      check("bp_next_word", 64'({s_ov, s_s, s_i1}), 64'({2'b11, 16'h5678}));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_drained", 64'(s_ov), 64'(0));
      @(posedge clk);
      #1;

      // Reset mid-transfer
      do_reset();
      in0_valid = 1'b1;
      in0_data  = 16'h1111;
      in1_valid = 1'b1;
      in1_data  = 16'h2222;
      @(posedge clk);
      #1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      @(negedge clk);
      check("mid_loaded", 64'({s_ov, s_s, s_i0, s_i1}), 64'({2'b10, 16'h1111, 16'h2222}));
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_async_reset", 64'({s_ov, s_s, s_r0, s_r1, s_i0, s_i1}), 64'({4'b0011, 16'h0, 16'h0}));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid_no_stale", 64'(s_ov), 64'(0));
      @(posedge clk);
      #1;
      exp_q.push_back({1'b1, 16'h3333});
      stream(0, 1, 16'h0000, 16'h3333);
      check("mid_first_cycle", 64'(first_pop), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
